// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned FETCH_ILEN = 32;
  localparam logic [FETCH_ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] insn;
    logic                  misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is zero while empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked by valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always @(posedge clk_i) begin
    if (!rst_i) assert (!(do_push && !do_pop && count_q == CW'(DEPTH)));
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: sequential PC generation, pipelined one-cycle
// imem requests, prefetch queue, redirect flush and misaligned-target trap.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter int unsigned     ILEN     = FETCH_ILEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_redirect,
  input  logic [XLEN-1:0]            i_redirect_pc,
  output logic                       o_imem_req,
  output logic [XLEN-1:0]            o_imem_addr,
  input  logic [ILEN-1:0]            i_imem_rdata,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [XLEN-1:0]            o_pc,
  output logic [ILEN-1:0]            o_insn,
  output logic                       o_misalign,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned OW = CW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic            inflight_q, inflight_d;
  logic            trap_q, trap_d;

  logic            redirect_c, misalign_c, deq_c, room_c, push_c;
  logic [OW-1:0]   occ_c;
  fetch_entry_t    push_entry, head_entry;

  // Redirect is ignored while reset is held.
  assign redirect_c = i_redirect & ~i_rst;
  assign misalign_c = |i_redirect_pc[1:0];
  assign deq_c      = o_valid & i_ready;
  assign occ_c      = OW'(o_count) + OW'(inflight_q) - OW'(deq_c);
  assign room_c     = occ_c < OW'(DEPTH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_c) state_d = misalign_c ? TRAP : RUN;
  end

  // Aligned redirect bypasses its target straight onto the request port.
  always_comb begin
    o_imem_req  = 1'b0;
    o_imem_addr = fetch_pc_q;
    if (i_rst) begin
      o_imem_addr = '0;
    end else if (redirect_c) begin
      o_imem_addr = i_redirect_pc;
      o_imem_req  = ~misalign_c;
    end else if (state_q == RUN) begin
      o_imem_req = room_c;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    trap_pc_d     = trap_pc_q;
    inflight_d    = o_imem_req;
    trap_d        = redirect_c & misalign_c;
    if (redirect_c && !misalign_c) fetch_pc_d = i_redirect_pc + XLEN'(4);
    else if (o_imem_req)           fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (o_imem_req) inflight_pc_d = o_imem_addr;
    if (trap_d)     trap_pc_d     = i_redirect_pc;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      trap_pc_q     <= '0;
      inflight_q    <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      trap_pc_q     <= trap_pc_d;
      inflight_q    <= inflight_d;
      trap_q        <= trap_d;
    end
  end

  // A redirect in the response cycle kills the pending response or trap entry.
  always_comb begin
    push_c     = (inflight_q | trap_q) & ~redirect_c;
    push_entry = '0;
    if (trap_q) begin
      push_entry.pc       = FETCH_XLEN'(trap_pc_q);
      push_entry.insn     = NOP;
      push_entry.misalign = 1'b1;
    end else begin
      push_entry.pc       = FETCH_XLEN'(inflight_pc_q);
      push_entry.insn     = FETCH_ILEN'(i_imem_rdata);
      push_entry.misalign = 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .flush_i(redirect_c),
    .push_i (push_c),
    .data_i (push_entry),
    .pop_i  (deq_c),
    .head_o (head_entry),
    .valid_o(o_valid),
    .count_o(o_count)
  );

  assign o_pc       = XLEN'(head_entry.pc);
  assign o_insn     = ILEN'(head_entry.insn);
  assign o_misalign = head_entry.misalign;

endmodule
